// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, write ports and reservation request.
// The master side is the issue/writeback logic; the slave side is the register file.
interface regfile_mp_if #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned NREAD     = 4,
  parameter int unsigned NWRITE    = 2
);
  localparam int unsigned DEPTH = 2**ADDRWIDTH;

  logic [NREAD*ADDRWIDTH-1:0]  rd_addr;
  logic [NREAD*DATAWIDTH-1:0]  rd_data;
  logic [NREAD-1:0]            rd_busy;
  logic [NWRITE-1:0]           wr_en;
  logic [NWRITE*ADDRWIDTH-1:0] wr_addr;
  logic [NWRITE*DATAWIDTH-1:0] wr_data;
  logic                        rsv_valid;
  logic [ADDRWIDTH-1:0]        rsv_addr;
  logic [DEPTH-1:0]            busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_valid, rsv_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_valid, rsv_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass and a busy-bit scoreboard.
// Optional build macro REGFILE_ZERO_REG_EN: register 0 is hardwired to zero and never busy.
module regfile_mp #(
  parameter int unsigned DATAWIDTH = 32,
  parameter int unsigned ADDRWIDTH = 4,
  parameter int unsigned NREAD     = 4,
  parameter int unsigned NWRITE    = 2
) (
  input  logic         clk,
  input  logic         reset,
  regfile_mp_if.slave  bus
);
  localparam int unsigned DEPTH = 2**ADDRWIDTH;

  logic [DATAWIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]     r_busy;
  logic [DEPTH-1:0]     w_busy_nxt;
  logic [ADDRWIDTH-1:0] w_wr_addr [NWRITE];
  logic [DATAWIDTH-1:0] w_wr_data [NWRITE];
  logic [NWRITE-1:0]    w_wr_ok;
  logic                 w_rsv_ok;

  // Unpack write ports; w_wr_ok is the effective enable used by storage, bypass and scoreboard
  for (genvar j = 0; j < int'(NWRITE); j++) begin : g_wr
    assign w_wr_addr[j] = bus.wr_addr[j*ADDRWIDTH +: ADDRWIDTH];
    assign w_wr_data[j] = bus.wr_data[j*DATAWIDTH +: DATAWIDTH];
`ifdef REGFILE_ZERO_REG_EN
    assign w_wr_ok[j]   = bus.wr_en[j] && (w_wr_addr[j] != '0);
`else
    assign w_wr_ok[j]   = bus.wr_en[j];
`endif
  end

`ifdef REGFILE_ZERO_REG_EN
  assign w_rsv_ok = bus.rsv_valid && (bus.rsv_addr != '0);
`else
  assign w_rsv_ok = bus.rsv_valid;
`endif

  // Later ports assign last, so the highest-indexed port wins a collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        r_mem[r] <= '0;
      end
    end else begin
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (w_wr_ok[j]) begin
          r_mem[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
    end
  end

  // Writes retire producers, then a same-edge reservation re-marks the register busy
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned j = 0; j < NWRITE; j++) begin
      if (w_wr_ok[j]) begin
        w_busy_nxt[w_wr_addr[j]] = 1'b0;
      end
    end
    if (w_rsv_ok) begin
      w_busy_nxt[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.busy_vec = r_busy;

  for (genvar i = 0; i < int'(NREAD); i++) begin : g_rd
    logic [ADDRWIDTH-1:0] w_ra;
    logic [DATAWIDTH-1:0] w_byp;

    assign w_ra = bus.rd_addr[i*ADDRWIDTH +: ADDRWIDTH];

    // Bypass: highest-indexed matching write port overrides stored value
    always_comb begin
      w_byp = r_mem[w_ra];
      for (int unsigned j = 0; j < NWRITE; j++) begin
        if (w_wr_ok[j] && (w_wr_addr[j] == w_ra)) begin
          w_byp = w_wr_data[j];
        end
      end
    end

    assign bus.rd_data[i*DATAWIDTH +: DATAWIDTH] = reset ? '0 : w_byp;
    assign bus.rd_busy[i]                        = reset ? 1'b0 : r_busy[w_ra];
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios then random traffic against a reference model.
module tb_regfile_mp;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned NR    = 4;
  localparam int unsigned NW    = 2;
  localparam int unsigned DEPTH = 2**AW;

  logic clk;
  logic rst;

  regfile_mp_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .NREAD(NR), .NWRITE(NW)) bus ();

  regfile_mp #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .NREAD(NR), .NWRITE(NW)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus state
  logic [AW-1:0] ra [NR];
  logic [NW-1:0] we;
  logic [AW-1:0] wa [NW];
  logic [DW-1:0] wd [NW];
  logic          rv;
  logic [AW-1:0] rsa;

  // Reference model
  logic [DW-1:0] m_mem  [DEPTH];
  logic          m_busy [DEPTH];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic model_clear();
    for (int r = 0; r < int'(DEPTH); r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic bool_zero_reg(input logic [AW-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return a == '0;
`else
    return 1'b0 && (a == '0);
`endif
  endfunction

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (rst) return '0;
    if (bool_zero_reg(a)) return '0;
    for (int j = int'(NW) - 1; j >= 0; j--) begin
      if (we[j] && wa[j] == a) return wd[j];
    end
    return m_mem[a];
  endfunction

  function automatic logic [DEPTH-1:0] exp_vec();
    logic [DEPTH-1:0] v;
    v = '0;
    for (int r = 0; r < int'(DEPTH); r++) v[r] = m_busy[r];
    return rst ? '0 : v;
  endfunction

  // Apply one clock edge worth of architectural effect
  task automatic model_commit();
    int win;
    if (rst) return;
    for (int r = 0; r < int'(DEPTH); r++) begin
      win = -1;
      for (int j = 0; j < int'(NW); j++) begin
        if (we[j] && wa[j] == AW'(r) && !bool_zero_reg(wa[j])) win = j;
      end
      if (win >= 0) begin
        m_mem[r]  = wd[win];
        m_busy[r] = 1'b0;
      end
    end
    if (rv && !bool_zero_reg(rsa)) m_busy[rsa] = 1'b1;
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NR); i++) bus.rd_addr[i*AW +: AW] = ra[i];
    for (int j = 0; j < int'(NW); j++) begin
      bus.wr_addr[j*AW +: AW] = wa[j];
      bus.wr_data[j*DW +: DW] = wd[j];
    end
    bus.wr_en     = we;
    bus.rsv_valid = rv;
    bus.rsv_addr  = rsa;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < int'(NR); i++) begin
      chk($sformatf("%s.rd_data%0d", tag, i), 64'(bus.rd_data[i*DW +: DW]), 64'(exp_rd(ra[i])));
      chk($sformatf("%s.rd_busy%0d", tag, i), 64'(bus.rd_busy[i]),
          64'(rst ? 1'b0 : m_busy[ra[i]]));
    end
    chk($sformatf("%s.busy_vec", tag), 64'(bus.busy_vec), 64'(exp_vec()));
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, a1, a2, a3);
    ra[0] = a0; ra[1] = a1; ra[2] = a2; ra[3] = a3;
  endtask

  task automatic set_wr(input logic [NW-1:0] en, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                        input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    we = en; wa[0] = a0; wd[0] = d0; wa[1] = a1; wd[1] = d1;
  endtask

  task automatic set_rsv(input logic v, input logic [AW-1:0] a);
    rv = v; rsa = a;
  endtask

  // Check pre-edge (bypass) view, then clock the current inputs into DUT and model
  task automatic step(input string tag);
    drive();
    #1;
    check_all(tag);
    @(posedge clk);
    model_commit();
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_clear();
    set_rd(0, 1, 2, 3);
    set_wr(2'b00, 0, '0, 0, '0);
    set_rsv(1'b0, 0);
    drive();
    @(posedge clk);
    @(posedge clk);
    #2;
    check_all("reset_hold");
    rst = 1'b0;

    // Basic writes on both ports
    set_rd(1, 2, 3, 4);
    set_wr(2'b11, 1, 32'hAAAAAAAA, 2, 32'hBBBBBBBB);
    step("wr_12");
    set_wr(2'b11, 3, 32'hCCCCCCCC, 4, 32'hDDDDDDDD);
    step("wr_34");
    set_wr(2'b01, 6, 32'h66666666, 8, 32'h88888888);
    step("wr_port0_only");
    set_wr(2'b00, 0, '0, 0, '0);
    step("rd_1234");
    set_rd(6, 8, 1, 4);
    step("rd_6_8");

    // Collision on reg5
    set_rd(5, 5, 5, 5);
    set_wr(2'b11, 5, 32'hFACECAFE, 5, 32'hDEADBEEF);
    step("collide_byp");
    set_wr(2'b00, 0, '0, 0, '0);
    step("collide_stored");

    // Bypass over a stored value
    set_rd(2, 2, 1, 5);
    step("byp_pre");
    set_wr(2'b01, 2, 32'h22222222, 0, '0);
    step("byp_same_cycle");
    set_wr(2'b00, 0, '0, 0, '0);
    step("byp_after");

    // Scoreboard
    set_rd(7, 9, 7, 1);
    set_rsv(1'b1, 7);
    step("rsv7");
    set_rsv(1'b0, 0);
    step("rsv7_busy");
    set_wr(2'b10, 0, '0, 7, 32'h77777777);
    step("wr7_busy_not_bypassed");
    set_wr(2'b00, 0, '0, 0, '0);
    step("wr7_cleared");
    set_wr(2'b01, 9, 32'h99999999, 0, '0);
    set_rsv(1'b1, 9);
    step("rsv_wr9");
    set_wr(2'b00, 0, '0, 0, '0);
    set_rsv(1'b0, 0);
    step("rsv_wr9_after");
    set_wr(2'b01, 10, 32'h10101010, 0, '0);
    set_rd(10, 9, 7, 0);
    step("wr_nonbusy");

    // Register 0 behaviour
    set_rd(0, 0, 10, 9);
    set_wr(2'b01, 0, 32'h12345678, 0, '0);
    set_rsv(1'b1, 0);
    step("reg0_byp");
    set_wr(2'b00, 0, '0, 0, '0);
    set_rsv(1'b0, 0);
    step("reg0_after");

    // Asynchronous reset between edges with writes active
    set_rd(1, 2, 9, 0);
    set_wr(2'b11, 1, 32'h11111111, 2, 32'h2222AAAA);
    drive();
    rst = 1'b1;
    model_clear();
    #1;
    check_all("rst_async");
    #2;
    set_wr(2'b00, 0, '0, 0, '0);
    drive();
    rst = 1'b0;
    step("rst_released");

    // Reset held across an edge discards that edge's write
    set_rd(3, 3, 1, 0);
    set_wr(2'b01, 3, 32'h33333333, 0, '0);
    set_rsv(1'b1, 3);
    drive();
    #6;
    rst = 1'b1;
    model_clear();
    #1;
    check_all("rst_edge");
    @(posedge clk);
    #2;
    rst = 1'b0;
    set_wr(2'b00, 0, '0, 0, '0);
    set_rsv(1'b0, 0);
    step("rst_edge_after");

    // Random traffic; narrow address range to provoke collisions and bypass hits
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < int'(NR); i++) ra[i] = AW'($urandom_range(0, 7));
      for (int j = 0; j < int'(NW); j++) begin
        wa[j] = AW'($urandom_range(0, 7));
        wd[j] = DW'($urandom);
      end
      we  = NW'($urandom);
      rv  = ($urandom_range(0, 3) == 0);
      rsa = AW'($urandom_range(0, 7));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; the next generation of the 4R/2W register file used by the datapath.
- Configurable depth, data width, read-port count and write-port count, with a per-port write enable on every write port.
- Combinational write-to-read bypass with deterministic priority.
- Adds a busy-bit scoreboard so the issue stage can detect in-flight producers. Sits between decode/issue and writeback.

Parameters:
- DATAWIDTH, 32, bits per register.
- ADDRWIDTH, 4, register address width; depth = 2**ADDRWIDTH.
- NREAD, 4, number of read ports (1..8).
- NWRITE, 2, number of write ports (1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all registers and busy bits.
- rd_addr  input  NREAD*ADDRWIDTH  read addresses; port i occupies slice i.
- rd_data  output  NREAD*DATAWIDTH  read data; port i occupies slice i.
- rd_busy  output  NREAD  busy bit of the addressed register, per read port.
- wr_en  input  NWRITE  per-port write enable.
- wr_addr  input  NWRITE*ADDRWIDTH  write addresses.
- wr_data  input  NWRITE*DATAWIDTH  write data.
- rsv_valid  input  1  reserve request: marks rsv_addr busy.
- rsv_addr  input  ADDRWIDTH  register to reserve.
- busy_vec  output  2**ADDRWIDTH  full scoreboard, bit r = register r busy.

Behaviour:
- Single clock domain. Reset is asynchronous and active-high.
- While reset=1:
  - all registers and busy bits read 0;
  - rd_data=0, rd_busy=0, busy_vec=0, regardless of wr_en (bypass suppressed).
- Reset asserted mid-operation discards any write on that edge.
- Write: on posedge clk, for each port j with wr_en[j]=1, reg[wr_addr_j] <= wr_data_j.
- Write collision (several enabled ports, same address): the highest-indexed port wins, both in storage and in bypass.
- Read is combinational. rd_data_i =
  - wr_data_j of the highest-indexed enabled port j with wr_addr_j == rd_addr_i, if any;
  - else reg[rd_addr_i].
- Bypass latency 0; stored-value latency 1 cycle.
- Scoreboard, on posedge clk:
  - an enabled write to register r clears busy[r];
  - rsv_valid=1 sets busy[rsv_addr].
- Same-edge reserve and write to the same r: reserve wins, busy[r]=1, because a new producer supersedes.
- rd_busy_i = busy[rd_addr_i], registered state only; not bypassed by same-cycle writes.
- busy_vec mirrors the busy register.
- Writes to a non-busy register are legal, store normally, and leave busy at 0.
- No internal state machine beyond the storage and scoreboard registers; all outputs are fully determined by the current state plus the combinational inputs above.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined:
  - register 0 is hardwired to 0 and writes to it are ignored;
  - reads of address 0 return 0 even under bypass;
  - rsv_valid to address 0 is ignored, so busy[0] stays 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset: load reg1=AAAAAAAA, then assert reset for 3 ns between edges -> rd_data=0 immediately on all ports; after release, read of reg1 returns 00000000 and busy_vec=0.
- Write/read: wr_en=11, write reg1=AAAAAAAA and reg2=BBBBBBBB; next cycle wr_en=11, write reg3=CCCCCCCC and reg4=DDDDDDDD; read addresses 1,2,3,4 -> AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD; wr_en=01 writes port 0 only.
- Collision: both ports write reg5 with port0=FACECAFE and port1=DEADBEEF -> same-cycle bypass and post-edge stored value are both DEADBEEF on all read ports.
- Bypass: reg2=BBBBBBBB stored; drive wr_en[0] with reg2=22222222 before the edge -> rd_data for address 2 is 22222222 in that cycle and is still 22222222 after the edge with wr_en=0.
- Scoreboard: rsv reg7 -> busy_vec[7]=1 and rd_busy for address 7 =1 next cycle; write reg7=77777777 -> busy clears after the edge. Same-edge rsv reg9 plus write reg9 -> busy[9]=1 and reg9 stores the written data.
- REGFILE_ZERO_REG_EN defined: write reg0=12345678 and rsv reg0 -> read of address 0 returns 0 in the bypass cycle and after, and busy[0]=0. Undefined build: the same stimulus returns 12345678 and busy[0]=1.
